// File: rtl/isa_pkg.sv
// Opcodes, instruction-word field positions and packer FSM states shared
// between the instruction packer and the decoder-side immediate generator.
package isa_pkg;

  localparam logic [4:0] OP_LUI  = 5'b10111;
  localparam logic [4:0] OP_ADDI = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b01000;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_LDI  = 5'b00100;

  // Word positions are MSB-first: bit 0 is the most significant bit.
  localparam int OP_LO  = 0;
  localparam int OP_HI  = 4;
  localparam int P1_LO  = 5;
  localparam int P1_HI  = 19;
  localparam int P2_LO  = 20;
  localparam int P2_HI  = 29;
  localparam int PAD_LO = 30;
  localparam int PAD_HI = 31;

  localparam int W_UIMM = 10;
  localparam int W_JAL  = 17;
  localparam int W_BR   = 12;
  localparam int W_LDI  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pk_state_e;

  // A value fits w signed bits when bits [31:w-1] are all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int w);
    logic [31:0] hi;
    hi = $unsigned($signed(v) >>> (w - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [31:0] v, input int w);
    return (v >> w) == '0;
  endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Field-beat stream and instruction-memory write port of the packer.
interface instr_packer_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [0:4]        in_op;
  logic [0:31]       in_imm;
  logic [0:14]       in_regs;
  logic              in_last;
  logic              mem_we;
  logic              mem_wready;
  logic [ADDR_W-1:0] mem_addr;
  logic [0:31]       mem_wdata;

  modport master (
    output in_valid, in_op, in_imm, in_regs, in_last, mem_wready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_regs, in_last, mem_wready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imm_scatter.sv
// Combinational encoder: range-checks the immediate for the opcode's format
// and scatters it, together with the register bits, into a 32-bit word.
module imm_scatter
  import isa_pkg::*;
(
  input  logic [0:4]  op,
  input  logic [0:31] imm,
  input  logic [0:14] regs,
  output logic [0:31] word,
  output logic        range_ok
);

  // Re-index to weight order so imm_w[k] carries weight 2^k.
  logic [31:0] imm_w;
  logic [4:0]  op_w;
  logic [0:14] p1;
  logic [0:9]  p2;

  assign imm_w = imm;
  assign op_w  = op;

  always_comb begin
    p1       = regs;
    p2       = imm_w[9:0];
    range_ok = 1'b1;
    case (op_w)
      OP_LUI, OP_ADDI: begin
        range_ok = fits_unsigned(imm_w, W_UIMM);
      end
      OP_JAL: begin
        range_ok = fits_signed(imm_w, W_JAL);
        p1[0:6]  = imm_w[16:10];
      end
      OP_BR: begin
        range_ok = fits_signed(imm_w, W_BR);
        p1[0]    = imm_w[11];
        p1[1:6]  = imm_w[9:4];
        p2[0:3]  = imm_w[3:0];
        p2[4]    = imm_w[10];
        p2[5:9]  = regs[10:14];
      end
      OP_LDI: begin
        range_ok = fits_signed(imm_w, W_LDI);
        p1       = imm_w[14:0];
        p2       = regs[5:14];
      end
      default: ;
    endcase
    word[OP_LO:OP_HI]   = op;
    word[P1_LO:P1_HI]   = p1;
    word[P2_LO:P2_HI]   = p2;
    word[PAD_LO:PAD_HI] = 2'b00;
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction loader: encodes field beats and writes them sequentially into
// instruction memory through a one-entry registered output buffer.
module instr_packer
  import isa_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter int          DEPTH  = 1024,
  parameter int unsigned BASE   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  instr_packer_if.slave  bus,
  output logic           busy,
  output logic           done,
  output logic           err_flag,
  output logic [7:0]     err_cnt
);

  localparam int                CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

  pk_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [0:31]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [0:31] word;
  logic        range_ok;
  logic        in_ready;
  logic        accept;

  imm_scatter u_scatter (
    .op       (bus.in_op),
    .imm      (bus.in_imm),
    .regs     (bus.in_regs),
    .word     (word),
    .range_ok (range_ok)
  );

  // A new beat may enter whenever the buffer is empty or draining this cycle.
  assign in_ready = (state_q == ST_RUN) && (!we_q || bus.mem_wready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wr_cnt_d   = wr_cnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;

    if (we_q && bus.mem_wready) begin
      we_d   = 1'b0;
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          addr_d     = BASE_ADDR;
          wr_cnt_d   = '0;
          err_flag_d = 1'b0;
          err_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (range_ok) begin
            we_d     = 1'b1;
            wdata_d  = word;
            wr_cnt_d = wr_cnt_q + 1'b1;
          end else begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
          if (bus.in_last) begin
            state_d = ST_DRAIN;
          end else if (range_ok && wr_cnt_q == LAST_CNT) begin
            // Window filled without a closing beat: flag the overflow.
            state_d    = ST_DRAIN;
            err_flag_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!we_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wr_cnt_q   <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wr_cnt_q   <= wr_cnt_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err_flag      = err_flag_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: table vectors, hand-written corner sequences and
// randomized sessions checked against an arithmetic reference encoder.
module tb_instr_packer;
  import isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start4, v, last, wready;
  logic [4:0]  op;
  logic [31:0] imm;
  logic [14:0] regs;
  bit          sel4;
  int          wr_mode;

  logic       busy, done, err_flag, busy4, done4, err_flag4;
  logic [7:0] err_cnt, err_cnt4;

  instr_packer_if #(.ADDR_W(10)) bus ();
  instr_packer_if #(.ADDR_W(10)) bus4 ();

  assign bus.in_valid    = v && !sel4;
  assign bus4.in_valid   = v && sel4;
  assign bus.in_op       = op;
  assign bus4.in_op      = op;
  assign bus.in_imm      = imm;
  assign bus4.in_imm     = imm;
  assign bus.in_regs     = regs;
  assign bus4.in_regs    = regs;
  assign bus.in_last     = last;
  assign bus4.in_last    = last;
  assign bus.mem_wready  = wready;
  assign bus4.mem_wready = wready;

  instr_packer #(.ADDR_W(10), .DEPTH(1024), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  instr_packer #(.ADDR_W(10), .DEPTH(4), .BASE(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4),
    .busy(busy4), .done(done4), .err_flag(err_flag4), .err_cnt(err_cnt4)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] imm;
    logic [14:0] regs;
    bit          ok;
    logic [31:0] word;
  } vec_t;

  wr_t         exp_q[$];
  int          n_checks = 0, n_fail = 0;
  int          done_cnt = 0, done4_cnt = 0, neg_idx = 0;
  int          last_we_idx = 0, last_done_idx = 0;
  logic [31:0] last_wdata = '0;
  logic [9:0]  exp_addr;
  int          exp_err;
  bit          hold_v = 0;
  logic [9:0]  hold_addr;
  logic [31:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder built from the format table with integer arithmetic.
  function automatic logic [32:0] ref_encode(input logic [4:0] o, input int im, input logic [14:0] r);
    int ri, p1, p2;
    bit ok;
    logic [31:0] w;
    ri = int'(r);
    ok = 1;
    p1 = ri;
    p2 = im & 1023;
    case (o)
      OP_LUI, OP_ADDI: ok = (im >= 0) && (im <= 1023);
      OP_JAL: begin
        ok = (im >= -65536) && (im <= 65535);
        p1 = (((im >>> 10) & 127) << 8) | (ri & 255);
      end
      OP_BR: begin
        ok = (im >= -2048) && (im <= 2047);
        p1 = (((im >>> 11) & 1) << 14) | (((im >>> 4) & 63) << 8) | (ri & 255);
        p2 = ((im & 15) << 6) | (((im >>> 10) & 1) << 5) | (ri & 31);
      end
      OP_LDI: begin
        ok = (im >= -16384) && (im <= 16383);
        p1 = im & 32'h7FFF;
        p2 = ri & 1023;
      end
      default: ;
    endcase
    w = (32'(o) << 27) | (32'(p1) << 12) | (32'(p2) << 2);
    return {ok, w};
  endfunction

  // Decoder-side view of a branch word: rebuild the signed 12-bit immediate.
  function automatic int decode_br(input logic [31:0] w);
    logic [11:0] i12;
    i12 = {w[26], w[7], w[25:20], w[11:8]};
    return int'($signed(i12));
  endfunction

  always @(negedge clk) begin
    neg_idx++;
    if (bus.mem_we === 1'b1 && hold_v) begin
      check("stall_addr_stable", 32'(bus.mem_addr), 32'(hold_addr));
      check("stall_data_stable", bus.mem_wdata, hold_data);
    end
    if (bus.mem_we === 1'b1 && wready === 1'b0) begin
      check("stall_in_ready_low", 32'(bus.in_ready), 32'd0);
      hold_v    = 1;
      hold_addr = bus.mem_addr;
      hold_data = bus.mem_wdata;
    end else begin
      hold_v = 0;
    end
    for (int k = 0; k < 2; k++) begin
      logic       we_k;
      logic [9:0] a_k;
      logic [31:0] d_k;
      we_k = (k == 0) ? bus.mem_we : bus4.mem_we;
      a_k  = (k == 0) ? bus.mem_addr : bus4.mem_addr;
      d_k  = (k == 0) ? bus.mem_wdata : bus4.mem_wdata;
      if (we_k === 1'b1 && wready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write", a_k, d_k);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(a_k), 32'(e.addr));
          check("wr_data", d_k, e.data);
          $display("write addr=%0d data=0x%08h", a_k, d_k);
        end
        last_wdata  = d_k;
        last_we_idx = neg_idx;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_done_idx = neg_idx;
    end
    if (done4 === 1'b1) done4_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (wr_mode == 1) wready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic try_send(input logic [4:0] o, input logic [31:0] im, input logic [14:0] r,
                          input logic l, input int budget, output bit acc);
    bit rdy;
    int n;
    op = o; imm = im; regs = r; last = l; v = 1; acc = 0; n = 0;
    while (!acc && n < budget) begin
      @(negedge clk);
      rdy = sel4 ? bus4.in_ready : bus.in_ready;
      @(posedge clk);
      #1;
      acc = rdy;
      n++;
    end
    v = 0; last = 0;
    $display("beat op=%b imm=%0d regs=0x%04h last=%0b accepted=%0b", o, $signed(im), r, l, acc);
  endtask

  task automatic begin_session;
    if (sel4) start4 = 1; else start = 1;
    tick;
    start = 0; start4 = 0;
    exp_addr = 10'd0;
    exp_err  = 0;
  endtask

  task automatic push_expect(input bit ok, input logic [31:0] w);
    if (ok) begin
      exp_q.push_back('{exp_addr, w});
      exp_addr++;
    end else if (exp_err < 255) begin
      exp_err++;
    end
  endtask

  task automatic send_model(input logic [4:0] o, input logic [31:0] im, input logic [14:0] r, input logic l);
    logic [32:0] m;
    bit acc;
    m = ref_encode(o, int'(im), r);
    push_expect(m[32], m[31:0]);
    try_send(o, im, r, l, 60, acc);
    check("beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic finish_session(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick;
      n++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("all_writes_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    $display("reset check %s", tag);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int d0, n_rej;
    bit acc;
    logic [31:0] blist[16];
    rst_n = 0; start = 0; start4 = 0; v = 0; last = 0;
    op = '0; imm = '0; regs = '0; wready = 1; wr_mode = 0; sel4 = 0;
    repeat (3) tick;
    @(negedge clk);
    check_reset_vals("power-on");
    @(posedge clk); #1;
    rst_n = 1;
    tick;

    // Single-beat sessions: write-to-done latency and branch round trip.
    begin_session; d0 = done_cnt;
    send_model(OP_LDI, -32'sd5, 15'd0, 1'b1);
    finish_session(d0);
    check("ldi_data", last_wdata, 32'h27FFB000);
    check("done_latency", 32'(last_done_idx - last_we_idx), 32'd2);

    begin_session; d0 = done_cnt;
    send_model(OP_BR, -32'sd2, 15'd0, 1'b1);
    finish_session(d0);
    check("br_roundtrip", 32'(decode_br(last_wdata)), -32'sd2);
    check("br_err_flag", 32'(err_flag), 32'd0);

    // Rejected beat carrying in_last still closes the session.
    begin_session; d0 = done_cnt;
    send_model(OP_LUI, 32'd1024, 15'd0, 1'b1);
    finish_session(d0);
    check("rej_last_err_cnt", 32'(err_cnt), 32'd1);
    check("rej_last_err_flag", 32'(err_flag), 32'd1);

    tbl[0] = '{OP_LDI,   -32'sd5,      15'h0000, 1'b1, 32'h27FFB000};
    tbl[1] = '{OP_LUI,   32'd1023,     15'h0000, 1'b1, 32'hB8000FFC};
    tbl[2] = '{OP_LUI,   32'd1024,     15'h0000, 1'b0, 32'h0};
    tbl[3] = '{OP_BR,    -32'sd2,      15'h0000, 1'b1, 32'hC7F00E80};
    tbl[4] = '{OP_ADDI,  -32'sd1,      15'h0000, 1'b0, 32'h0};
    tbl[5] = '{OP_JAL,   32'd65535,    15'h0000, 1'b1, 32'h43F00FFC};
    tbl[6] = '{OP_JAL,   32'd65536,    15'h0000, 1'b0, 32'h0};
    tbl[7] = '{OP_LDI,   32'd16384,    15'h0000, 1'b0, 32'h0};
    tbl[8] = '{5'b11111, 32'hFFFFFFFF, 15'h7FFF, 1'b1, 32'hFFFFFFFC};
    tbl[9] = '{OP_JAL,   -32'sd65536,  15'h7FFF, 1'b1, 32'h440FF000};
    begin_session; d0 = done_cnt; n_rej = 0;
    for (int i = 0; i < 10; i++) begin
      push_expect(tbl[i].ok, tbl[i].word);
      if (!tbl[i].ok) n_rej++;
      try_send(tbl[i].op, tbl[i].imm, tbl[i].regs, (i == 9), 60, acc);
      check("tbl_accepted", 32'(acc), 32'd1);
    end
    finish_session(d0);
    check("tbl_err_cnt", 32'(err_cnt), 32'(n_rej));
    check("tbl_err_flag", 32'(err_flag), 32'd1);

    // Memory stalls for 5 cycles under a 3-beat stream.
    begin_session; d0 = done_cnt;
    wready = 0;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send_model(OP_LDI, 32'(i + 1), 15'(i * 7), (i == 2));
      end
      begin
        repeat (5) tick;
        wready = 1;
      end
    join
    finish_session(d0);

    // Randomized sessions with random write back-pressure and input gaps.
    blist = '{-32'sd65537, -32'sd65536, -32'sd2049, -32'sd2048, 32'd2047, 32'd2048,
              -32'sd16385, -32'sd16384, 32'd16383, 32'd16384, 32'd1023, 32'd1024,
              32'd65535, 32'd65536, -32'sd1, 32'd0};
    wr_mode = 1;
    for (int s = 0; s < 3; s++) begin
      begin_session; d0 = done_cnt;
      for (int i = 0; i < 30; i++) begin
        logic [4:0]  o;
        logic [31:0] im;
        case ($urandom_range(0, 5))
          0: o = OP_LUI;
          1: o = OP_ADDI;
          2: o = OP_JAL;
          3: o = OP_BR;
          4: o = OP_LDI;
          default: o = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: im = 32'($urandom_range(0, 2047)) - 32'd1024;
          1: im = blist[$urandom_range(0, 15)];
          2: im = $urandom;
          default: im = 32'($urandom_range(0, 1023));
        endcase
        if ($urandom_range(0, 3) == 0) tick;
        send_model(o, im, 15'($urandom), (i == 29));
      end
      finish_session(d0);
      check("rnd_err_cnt", 32'(err_cnt), 32'(exp_err));
      check("rnd_err_flag", 32'(err_flag), 32'(exp_err != 0));
    end
    wr_mode = 0;
    tick;
    wready = 1;

    // DEPTH=4 instance: six beats without last.
    sel4 = 1;
    begin_session; d0 = done4_cnt;
    for (int i = 0; i < 4; i++) send_model(OP_LDI, 32'(100 + i), 15'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      try_send(OP_LDI, 32'd9, 15'd0, 1'b0, 10, acc);
      check("overflow_not_accepted", 32'(acc), 32'd0);
    end
    check("depth_done_pulses", 32'(done4_cnt - d0), 32'd1);
    check("depth_err_flag", 32'(err_flag4), 32'd1);
    check("depth_err_cnt", 32'(err_cnt4), 32'd0);
    check("depth_busy", 32'(busy4), 32'd0);
    check("depth_writes", 32'(exp_q.size()), 32'd0);
    sel4 = 0;

    // Reset while a write is pending aborts without a done pulse.
    begin_session;
    wready = 0;
    push_expect(1'b1, 32'h0);
    try_send(OP_LDI, 32'd7, 15'd0, 1'b0, 20, acc);
    check("abort_beat_accepted", 32'(acc), 32'd1);
    tick;
    check("abort_pending", 32'(bus.mem_we), 32'd1);
    d0 = done_cnt;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_reset_vals("mid-session");
    exp_q.delete();
    wready = 1;
    repeat (10) tick;
    check("abort_no_done", 32'(done_cnt), 32'(d0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
